// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost flags, optional FWFT read, sync flush and sticky errors.
// Read latency 1 (FWFT=0) or 0 (FWFT=1); writes to a full FIFO and reads from an empty one are dropped and flagged.
module sync_fifo_flex #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("sync_fifo_flex: ADDR_WIDTH must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("sync_fifo_flex: DATA_WIDTH must be >= 1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_flex: FWFT must be 0 or 1");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_LEVEL out of range 1..DEPTH");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wfull_q, wfull_d;
  logic                  rempty_q, rempty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wincr, rincr;

  // Accepts are judged against the registered flags, so a full FIFO still pops on wen&ren.
  assign wincr = wen & ~wfull_q & ~clear;
  assign rincr = ren & ~rempty_q & ~clear;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wen & wfull_q);
    unf_d   = unf_q | (ren & rempty_q);
    if (wincr) wptr_d = wptr_q + 1'b1;
    if (rincr) rptr_d = rptr_q + 1'b1;
    unique case ({wincr, rincr})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end
    wfull_d  = (count_d == DEPTH_C);
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wincr) mem_q[wptr_q] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_q[rptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   rdata_q <= '0;
      else if (rincr) rdata_q <= mem_q[rptr_q];
    end
    assign rdata = rdata_q;
  end

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench: two ADDR_WIDTH=2 FIFOs (standard and FWFT) share stimulus and are checked against a queue model.
module tb_sync_fifo_flex;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic wen = 1'b0;
  logic ren = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic          wfull0, afull0, rempty0, aempty0, ovf0, unf0;
  logic          wfull1, afull1, rempty1, aempty1, ovf1, unf1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW:0]   count0, count1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata0 = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_std (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wen(wen), .wdata(wdata),
    .wfull(wfull0), .walmost_full(afull0), .ren(ren), .rdata(rdata0),
    .rempty(rempty0), .ralmost_empty(aempty0), .count(count0),
    .overflow(ovf0), .underflow(unf0));

  sync_fifo_flex #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wen(wen), .wdata(wdata),
    .wfull(wfull1), .walmost_full(afull1), .ren(ren), .rdata(rdata1),
    .rempty(rempty1), .ralmost_empty(aempty1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, " count0"}, 32'(count0), 32'(n));
    chk({tag, " count1"}, 32'(count1), 32'(n));
    chk({tag, " wfull0"}, 32'(wfull0), 32'(n == D));
    chk({tag, " wfull1"}, 32'(wfull1), 32'(n == D));
    chk({tag, " rempty0"}, 32'(rempty0), 32'(n == 0));
    chk({tag, " rempty1"}, 32'(rempty1), 32'(n == 0));
    chk({tag, " afull0"}, 32'(afull0), 32'(n >= 2));
    chk({tag, " afull1"}, 32'(afull1), 32'(n >= 2));
    chk({tag, " aempty0"}, 32'(aempty0), 32'(n <= 1));
    chk({tag, " aempty1"}, 32'(aempty1), 32'(n <= 1));
    chk({tag, " ovf0"}, 32'(ovf0), 32'(m_ovf));
    chk({tag, " ovf1"}, 32'(ovf1), 32'(m_ovf));
    chk({tag, " unf0"}, 32'(unf0), 32'(m_unf));
    chk({tag, " unf1"}, 32'(unf1), 32'(m_unf));
    chk({tag, " rdata0"}, 32'(rdata0), 32'(m_rdata0));
    if (n > 0) chk({tag, " rdata1"}, 32'(rdata1), 32'(q[0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata0 = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock: drive at negedge, update the queue model at the edge, check 1 time unit later.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] wd,
                      input logic r, input logic c);
    bit full, empty;
    @(negedge clk);
    wen = w; wdata = wd; ren = r; clear = c;
    @(posedge clk);
    full  = (q.size() == D);
    empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && full)  m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
      if (r && !empty) m_rdata0 = q.pop_front();
      if (w && !full)  q.push_back(wd);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill, then overflow write.
    step("t1_w1", 1, 8'hA1, 0, 0);
    step("t1_w2", 1, 8'hA2, 0, 0);
    step("t1_w3", 1, 8'hA3, 0, 0);
    step("t1_w4", 1, 8'hA4, 0, 0);
    step("t1_ovf", 1, 8'hA5, 0, 0);

    // Drain and underflow; standard rdata must hold A4.
    for (int i = 0; i < 4; i++) step("t2_rd", 0, 8'h00, 1, 0);
    step("t2_unf", 0, 8'h00, 1, 0);
    chk("t2_hold_a4", 32'(rdata0), 32'hA4);

    // Single word falls through on the FWFT instance.
    step("t3_w55", 1, 8'h55, 0, 0);
    chk("t3_fwft55", 32'(rdata1), 32'h55);
    step("t3_rd", 0, 8'h00, 1, 0);

    // Full with simultaneous wen/ren, then steady state at count 2.
    for (int i = 0; i < 4; i++) step("t4_fill", 1, 8'(8'hB0 + i), 0, 0);
    step("t4_full_wr", 1, 8'hBF, 1, 0);
    step("t4_rd", 0, 8'h00, 1, 0);
    step("t4_mid_wr", 1, 8'hC0, 1, 0);
    step("t4_mid_wr2", 1, 8'hC1, 1, 0);
    for (int i = 0; i < 2; i++) step("t4_drain", 0, 8'h00, 1, 0);

    // Interleaved traffic wraps the pointers.
    for (int i = 0; i < 6; i++) begin
      step("t5_w", 1, 8'(8'hD0 + i), 0, 0);
      step("t5_wr", 1, 8'(8'hE0 + i), 1, 0);
      step("t5_r", 0, 8'h00, 1, 0);
    end
    while (q.size() > 0) step("t5_drain", 0, 8'h00, 1, 0);

    // Clear beats a simultaneous write.
    for (int i = 0; i < 5; i++) step("t6_fill", 1, 8'(8'h60 + i), 0, 0);
    step("t6_rd", 0, 8'h00, 1, 0);
    chk("t6_ovf_set", 32'(ovf0), 32'h1);
    step("t6_clr", 1, 8'h77, 0, 1);
    chk("t6_rdata_kept", 32'(rdata0), 32'h60);
    step("t6_after", 0, 8'h00, 0, 0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 5; i++) step("t6_refill", 1, 8'(8'h90 + i), 0, 0);
    step("t6_rd2", 0, 8'h00, 1, 0);
    step("t6_unf_seed", 0, 8'h00, 0, 0);
    @(negedge clk);
    wen = 1'b0; ren = 1'b0; clear = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_arst");
    @(negedge clk);
    reset_n = 1'b1;
    step("t6_post_arst", 1, 8'h3C, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 55), 8'($urandom),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
